digit_scan_ctrl: RTL and testbench
==================================

Name: digit_scan_ctrl

Overview:
Time-multiplexing scheduler that shares one segment/value bus between NDIG display digits. It generalises the two-digit complementary select to N digits with a programmable dwell time and a dead-time blanking gap between digits, which prevents ghosting. Display data is double-buffered: a new word is committed only at a frame boundary, so a frame never tears. It sits between the value-producing datapath (ALU result register) and the digit decoder/drivers.

Parameters:
NDIG, 4, number of digits scanned (>=2)
DW, 4, bits per digit value
DWELL, 50000, cycles each digit is enabled (>=1)
BLANK, 16, dead-time cycles with all digits off between digits (>=0; 0 = no gap)

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
LOAD  input  1  one-cycle strobe: capture DATA_IN into shadow buffer
DATA_IN  input  NDIG*DW  digit values, digit i at [i*DW +: DW]
DIG_EN  output  NDIG  one-hot active-high digit enable; all-zero while blanking
DIG_VAL  output  DW  value for the enabled digit; 0 while blanking
DIG_IDX  output  clog2(NDIG)  index of current/next digit
PENDING  output  1  shadow holds data not yet committed
FRAME_TICK  output  1  one-cycle pulse when the last digit's dwell ends

Behaviour:
- One clock CLK; reset RST is asynchronous and active-high. All outputs are registered.
- Reset values:
  - state=S_BLANK, cnt=0, DIG_IDX=0, DIG_EN=0, DIG_VAL=0.
  - Active buffer = 0, shadow buffer = 0, PENDING=0, FRAME_TICK=0.
- FSM states: S_BLANK, S_ON.
- S_BLANK:
  - DIG_EN=0 and DIG_VAL=0; cnt counts 0..BLANK-1.
  - On the cycle cnt==BLANK-1: go to S_ON, cnt<=0, DIG_EN<=onehot(DIG_IDX), DIG_VAL<=active[DIG_IDX].
  - If BLANK==0, S_BLANK is never entered after reset. The first post-reset cycle goes directly to S_ON.
- S_ON:
  - DIG_EN and DIG_VAL are held for exactly DWELL cycles; cnt counts 0..DWELL-1.
  - At cnt==DWELL-1, DIG_IDX<=DIG_IDX+1, wrapping NDIG-1 -> 0, and cnt<=0.
  - Next state is S_BLANK, or S_ON with the new digit if BLANK==0.
- Frame boundary (leaving S_ON with DIG_IDX==NDIG-1):
  - FRAME_TICK=1 for the following single cycle.
  - If PENDING, active<=shadow and PENDING<=0 in that same edge. Digit 0 of the next frame shows the new data.
- LOAD behaviour:
  - LOAD: shadow<=DATA_IN, PENDING<=1.
  - Repeated LOAD before commit: last write wins; no loss indication.
  - LOAD on the same edge as a commit: DATA_IN goes straight to active, shadow<=DATA_IN, PENDING<=0. Newest data wins; the older shadow is discarded.
- Invariants:
  - DIG_EN is never multi-hot.
  - A digit never switches to another digit without BLANK zero cycles in between.
  - Period per digit is DWELL+BLANK; frame period is NDIG*(DWELL+BLANK).
- Reset mid-operation: everything returns to reset values immediately and asynchronously. DIG_EN=0 while RST is high. The scan restarts at digit 0 with a full blank gap.
- cnt width is clog2(max(DWELL,BLANK,1)). No other arithmetic; the index wraps explicitly, not by natural overflow, because NDIG may be a non-power-of-2.

Decomposition:
- Package disp_pkg: state enum {S_BLANK,S_ON} and a clog2 helper function.
- Sub-module scan_timer: a down/up counter with terminal-count pulse, reloaded with DWELL or BLANK on state change. The FSM, index and buffers stay in digit_scan_ctrl.

Test Plan:
- Reset, NDIG=4, DWELL=3, BLANK=2 -> DIG_EN=0 for 2 cycles, then 0001 for 3 cycles, 0000 for 2 cycles, then 0010 for 3. FRAME_TICK pulses once every 20 cycles.
- LOAD with DATA_IN=16'h4321 mid-frame -> PENDING=1. Current frame still shows 0. After FRAME_TICK, digits show 1,2,3,4 and PENDING=0.
- Two LOADs (16'h1111 then 16'h2222) in one frame -> next frame shows 2 on all digits.
- LOAD=16'h5A5A exactly on the commit edge with shadow=16'h1111 -> next frame shows A,5,A,5 and PENDING=0.
- BLANK=0, NDIG=3 -> DIG_EN goes 001 -> 010 -> 100 -> 001 with no all-zero cycle. Assertion checks one-hot on every cycle.
- Assert RST while digit 2 is on -> DIG_EN=0 in the same cycle, before the clock edge. After release, the scan restarts at digit 0 after BLANK cycles, and the buffer holds 0.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and width helpers for the multiplexed digit scanner.
package disp_pkg;

  typedef enum logic {S_BLANK = 1'b0, S_ON = 1'b1} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Register width for a range of v values; never zero so vectors stay legal.
  function automatic int wbits(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Datapath-facing load port and display-driver outputs of the digit scanner.
interface digit_scan_ctrl_if #(
  parameter int NDIG = 4,
  parameter int DW   = 4
);
  import disp_pkg::*;
  localparam int IW = wbits(NDIG);

  logic                 LOAD;
  logic [NDIG*DW-1:0]   DATA_IN;
  logic [NDIG-1:0]      DIG_EN;
  logic [DW-1:0]        DIG_VAL;
  logic [IW-1:0]        DIG_IDX;
  logic                 PENDING;
  logic                 FRAME_TICK;

  modport master (
    output LOAD, DATA_IN,
    input  DIG_EN, DIG_VAL, DIG_IDX, PENDING, FRAME_TICK
  );

  modport slave (
    input  LOAD, DATA_IN,
    output DIG_EN, DIG_VAL, DIG_IDX, PENDING, FRAME_TICK
  );

endinterface

// File: rtl/digit_scan_ctrl_scan_timer.sv
// Phase counter: counts up to a state-dependent limit, pulses tc and restarts at 0.
module scan_timer #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] lim_i,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // The FSM changes state exactly on tc, so wrapping here doubles as the reload.
  assign tc_o  = (cnt_q == lim_i);
  assign cnt_d = tc_o ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// N-digit time-multiplexed display scanner with dwell/blank timing and a
// double-buffered value word committed only at frame boundaries.
module digit_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int DW    = 4,
  parameter int DWELL = 50000,
  parameter int BLANK = 16
) (
  input  logic             CLK,
  input  logic             RST,
  digit_scan_ctrl_if.slave bus
);

  localparam int IW   = wbits(NDIG);
  localparam int MAXC = (DWELL > BLANK) ? DWELL : ((BLANK > 1) ? BLANK : 1);
  localparam int CW   = wbits(MAXC);
  localparam logic [CW-1:0] ON_LIM = CW'(DWELL - 1);
  // With no gap the blank limit is 0, so the reset cycle falls straight into S_ON.
  localparam logic [CW-1:0] BL_LIM = CW'((BLANK == 0) ? 0 : BLANK - 1);
  localparam logic [IW-1:0] LAST   = IW'(NDIG - 1);

  state_e             state_q;
  logic [IW-1:0]      idx_q, idx_nxt;
  logic [NDIG*DW-1:0] active_q, active_d, shadow_q;
  logic               pending_q, tick_q;
  logic [NDIG-1:0]    en_q;
  logic [DW-1:0]      val_q;
  logic [CW-1:0]      lim;
  logic               tc, frame_end, commit;

  function automatic logic [NDIG-1:0] onehot(input logic [IW-1:0] i);
    logic [NDIG-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  assign lim = (state_q == S_ON) ? ON_LIM : BL_LIM;

  scan_timer #(.CW(CW)) u_timer (
    .clk   (CLK),
    .rst   (RST),
    .lim_i (lim),
    .tc_o  (tc)
  );

  // Explicit wrap: NDIG need not be a power of two.
  assign idx_nxt   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
  assign frame_end = (state_q == S_ON) && tc && (idx_q == LAST);
  assign commit    = frame_end && pending_q;

  // A LOAD landing on the commit edge bypasses the shadow; newest data wins.
  always_comb begin
    active_d = active_q;
    if (commit) active_d = bus.LOAD ? bus.DATA_IN : shadow_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_BLANK;
      idx_q     <= '0;
      en_q      <= '0;
      val_q     <= '0;
      active_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      tick_q   <= frame_end;
      active_q <= active_d;
      if (bus.LOAD) begin
        shadow_q  <= bus.DATA_IN;
        pending_q <= 1'b1;
      end
      if (commit) pending_q <= 1'b0;

      unique case (state_q)
        S_BLANK: begin
          if (tc) begin
            state_q <= S_ON;
            en_q    <= onehot(idx_q);
            val_q   <= active_q[int'(idx_q)*DW +: DW];
          end
        end
        S_ON: begin
          if (tc) begin
            idx_q <= idx_nxt;
            if (BLANK == 0) begin
              // Back-to-back digits: read the post-commit word so digit 0 is fresh.
              en_q  <= onehot(idx_nxt);
              val_q <= active_d[int'(idx_nxt)*DW +: DW];
            end else begin
              state_q <= S_BLANK;
              en_q    <= '0;
              val_q   <= '0;
            end
          end
        end
        default: state_q <= S_BLANK;
      endcase
    end
  end

  assign bus.DIG_EN     = en_q;
  assign bus.DIG_VAL    = val_q;
  assign bus.DIG_IDX    = idx_q;
  assign bus.PENDING    = pending_q;
  assign bus.FRAME_TICK = tick_q;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Randomized check of two scanner configurations against a time-based reference model.
module tb_digit_scan_ctrl;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   errs = 0;
  int   nchk = 0;

  // Reference model: cycle number since reset release plus buffer contents.
  int          k, nd, per, bl, off;
  logic [31:0] act, shd, mask;
  bit          pend;
  bit          hit;

  always #5 clk = ~clk;

  digit_scan_ctrl_if #(.NDIG(4), .DW(4)) b0 ();
  digit_scan_ctrl_if #(.NDIG(3), .DW(4)) b1 ();

  digit_scan_ctrl #(.NDIG(4), .DW(4), .DWELL(3), .BLANK(2)) u0 (
    .CLK(clk), .RST(rst0), .bus(b0)
  );
  digit_scan_ctrl #(.NDIG(3), .DW(4), .DWELL(2), .BLANK(0)) u1 (
    .CLK(clk), .RST(rst1), .bus(b1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, k);
    end
  endtask

  function automatic int slot();
    return ((k - off) / per) % nd;
  endfunction

  function automatic logic [31:0] exp_en();
    if (k < off) return 32'd0;
    if (((k - off) % per) < bl) return 32'd0;
    return 32'd1 << slot();
  endfunction

  function automatic logic [31:0] exp_idx();
    return (k < off) ? 32'd0 : 32'(slot());
  endfunction

  function automatic logic [31:0] exp_val();
    if (exp_en() == 32'd0) return 32'd0;
    return (act >> (4 * slot())) & 32'hF;
  endfunction

  function automatic logic [31:0] exp_tick();
    return 32'(((k - off) > 0) && (((k - off) % (nd * per)) == 0));
  endfunction

  function automatic bit is_fe();
    return (k >= off) && (((k - off) % (nd * per)) == nd * per - 1);
  endfunction

  task automatic set_cfg(input int c);
    if (c == 0) begin nd = 4; per = 5; bl = 2; off = 0; mask = 32'hFFFF; end
    else        begin nd = 3; per = 2; bl = 0; off = 1; mask = 32'hFFF;  end
  endtask

  task automatic model_reset();
    k = 0; act = '0; shd = '0; pend = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [31:0] d);
    if (is_fe() && pend) begin
      act  = ld ? d : shd;
      pend = 1'b0;
      if (ld) shd = d;
    end else if (ld) begin
      shd  = d;
      pend = 1'b1;
    end
  endtask

  task automatic check_cycle(input int c);
    logic [31:0] en, val, idx, pd, tk;
    if (c == 0) begin
      en = 32'(b0.DIG_EN); val = 32'(b0.DIG_VAL); idx = 32'(b0.DIG_IDX);
      pd = 32'(b0.PENDING); tk = 32'(b0.FRAME_TICK);
    end else begin
      en = 32'(b1.DIG_EN); val = 32'(b1.DIG_VAL); idx = 32'(b1.DIG_IDX);
      pd = 32'(b1.PENDING); tk = 32'(b1.FRAME_TICK);
    end
    chk("dig_en", en, exp_en());
    chk("dig_val", val, exp_val());
    chk("dig_idx", idx, exp_idx());
    chk("pending", pd, 32'(pend));
    chk("frame_tick", tk, exp_tick());
    chk("onehot0", 32'($onehot0(en)), 32'd1);
  endtask

  task automatic drive(input int c, input logic ld, input logic [31:0] d);
    if (c == 0) begin b0.LOAD = ld; b0.DATA_IN = d[15:0]; end
    else        begin b1.LOAD = ld; b1.DATA_IN = d[11:0]; end
  endtask

  // Called at a falling edge; each iteration checks cycle k then drives the next rising edge.
  task automatic run(input int c, input int n, input bit dir, input bit stop2, output bit reached);
    logic        ld;
    logic [31:0] d;
    reached = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      check_cycle(c);
      if (stop2 && exp_en() == 32'd4) begin
        reached = 1'b1;
        return;
      end
      d  = $urandom & mask;
      ld = ($urandom_range(0, 7) == 0) || (is_fe() && $urandom_range(0, 1) == 0);
      if (dir) begin
        case (k)
          7:       begin ld = 1'b1; d = 32'h4321; end
          27:      begin ld = 1'b1; d = 32'h1111; end
          30:      begin ld = 1'b1; d = 32'h2222; end
          45:      begin ld = 1'b1; d = 32'h1111; end
          59:      begin ld = 1'b1; d = 32'h5A5A; end
          default: if (k < 80) ld = 1'b0;
        endcase
      end
      drive(c, ld, d);
      model_edge(ld, d);
      k++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    b0.LOAD = 1'b0; b0.DATA_IN = '0;
    b1.LOAD = 1'b0; b1.DATA_IN = '0;
    k = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_en0", 32'(b0.DIG_EN), 32'd0);
    chk("rst_val0", 32'(b0.DIG_VAL), 32'd0);
    chk("rst_pend0", 32'(b0.PENDING), 32'd0);
    chk("rst_tick0", 32'(b0.FRAME_TICK), 32'd0);
    chk("rst_en1", 32'(b1.DIG_EN), 32'd0);

    // Config 0: dwell 3, blank 2, directed loads in the first frames then random.
    @(negedge clk);
    rst0 = 1'b0;
    set_cfg(0);
    model_reset();
    run(0, 300, 1'b1, 1'b0, hit);

    // Asynchronous reset while digit 2 is lit.
    run(0, 100, 1'b0, 1'b1, hit);
    chk("reach_dig2", 32'(hit), 32'd1);
    b0.LOAD = 1'b0;
    rst0    = 1'b1;
    #1;
    chk("async_en", 32'(b0.DIG_EN), 32'd0);
    chk("async_val", 32'(b0.DIG_VAL), 32'd0);
    chk("async_idx", 32'(b0.DIG_IDX), 32'd0);
    chk("async_pend", 32'(b0.PENDING), 32'd0);
    @(negedge clk);
    rst0 = 1'b0;
    model_reset();
    run(0, 200, 1'b0, 1'b0, hit);

    // Config 1: three digits, no blanking gap.
    set_cfg(1);
    @(negedge clk);
    rst1 = 1'b0;
    model_reset();
    run(1, 300, 1'b0, 1'b0, hit);

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule
